// File: rtl/cmp_search_ctrl_if.sv
// Bundle of signals between the binary-search controller and its magnitude comparator
// and requester. The master side is the search controller: it drives the probe and the
// result outputs, and it receives start and the comparator flags. The slave side is the
// environment that holds the hidden target and issues start.
interface cmp_search_ctrl_if #(
    parameter int WIDTH = 2
);
    logic             start;
    logic [WIDTH-1:0] probe;
    logic             probe_vld;
    logic             cmp_g;
    logic             cmp_e;
    logic             cmp_l;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        input  start,
        input  cmp_g,
        input  cmp_e,
        input  cmp_l,
        output probe,
        output probe_vld,
        output busy,
        output done,
        output result,
        output found,
        output err
    );

    modport slave (
        output start,
        output cmp_g,
        output cmp_e,
        output cmp_l,
        input  probe,
        input  probe_vld,
        input  busy,
        input  done,
        input  result,
        input  found,
        input  err
    );
endinterface

// File: rtl/cmp_search_ctrl.sv
// cmp_search_ctrl: binary-search initiator for a 2:1 magnitude comparator.
// The comparator holds the hidden target on its a side and sees probe on its b side.
// Each sampled compare narrows the [lo, hi] window until the target is hit, the window
// collapses, or the comparator returns flags that are not one-hot.
//
// Optional build macro CMP_SEARCH_SETTLE_EN: every compare takes two cycles, a SETTLE
// cycle in which the new probe propagates through a registered comparator (flags
// ignored, probe_vld low) followed by a SEARCH cycle in which the flags are sampled.
// Without the macro each SEARCH cycle samples the flags directly.
module cmp_search_ctrl #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_search_ctrl_if.master bus
);

    localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
    // (0 + all ones) >> 1 is simply all ones shifted right by one
    localparam logic [WIDTH-1:0] FIRST_PROBE = ALL_ONES >> 1;

`ifdef CMP_SEARCH_SETTLE_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SEARCH = 2'd2,
        S_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             err_q, err_d;

    logic [2:0]       flags;
    logic             flags_one_hot;
    logic [WIDTH-1:0] lo_up;
    logic [WIDTH-1:0] hi_down;
    logic [WIDTH:0]   sum_after_g;
    logic [WIDTH:0]   sum_after_l;

    // The sampling state differs between the two builds: after a window update we either
    // sample again immediately or spend one cycle letting the comparator settle.
`ifdef CMP_SEARCH_SETTLE_EN
    localparam state_t AFTER_UPDATE = S_SETTLE;
`else
    localparam state_t AFTER_UPDATE = S_SEARCH;
`endif

    assign flags         = {bus.cmp_g, bus.cmp_e, bus.cmp_l};
    assign flags_one_hot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

    // Window edges after a g or l answer; only used when they cannot wrap, since the
    // probe==hi and probe==lo cases end the search instead of updating.
    assign lo_up   = probe_q + WIDTH'(1);
    assign hi_down = probe_q - WIDTH'(1);

    // Midpoints use one extra bit so lo+hi never overflows before the halving.
    assign sum_after_g = {1'b0, lo_up} + {1'b0, hi_q};
    assign sum_after_l = {1'b0, lo_q}  + {1'b0, hi_down};

    // State register plus all datapath registers, cleared asynchronously so an
    // in-flight search is abandoned without ever reaching DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= ALL_ONES;
            probe_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    // Next-state and next-datapath decisions; everything holds unless a branch changes it.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lo_d     = '0;
                    hi_d     = ALL_ONES;
                    probe_d  = FIRST_PROBE;
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = AFTER_UPDATE;
                end
            end

`ifdef CMP_SEARCH_SETTLE_EN
            S_SETTLE: begin
                state_d = S_SEARCH;
            end
`endif

            S_SEARCH: begin
                if (!flags_one_hot) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = probe_q;
                    state_d  = S_DONE;
                end else if (bus.cmp_e) begin
                    found_d  = 1'b1;
                    result_d = probe_q;
                    state_d  = S_DONE;
                end else if (bus.cmp_g) begin
                    if (probe_q == hi_q) begin
                        found_d  = 1'b0;
                        result_d = probe_q;
                        state_d  = S_DONE;
                    end else begin
                        lo_d    = lo_up;
                        probe_d = sum_after_g[WIDTH:1];
                        state_d = AFTER_UPDATE;
                    end
                end else begin
                    if (probe_q == lo_q) begin
                        found_d  = 1'b0;
                        result_d = probe_q;
                        state_d  = S_DONE;
                    end else begin
                        hi_d    = hi_down;
                        probe_d = sum_after_l[WIDTH:1];
                        state_d = AFTER_UPDATE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.probe     = probe_q;
    assign bus.probe_vld = (state_q == S_SEARCH);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.found     = found_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// tb_cmp_search_ctrl: directed bench for cmp_search_ctrl with WIDTH=2.
// A behavioural comparator holds the target; it can be forced to give malformed
// (g and l together) or always-less answers. Expected probes, latencies and results
// are hand-computed constants. With CMP_SEARCH_SETTLE_EN defined the two-cycle
// compare variant is exercised instead of the single-cycle one.
module tb_cmp_search_ctrl;

    logic clk;
    logic rst_n;

    logic [1:0] target;
    bit         force_gl;
    bit         force_l;

    int n_checks;
    int n_pass;

    int          lat;
    int          np;
    logic [15:0] plog;
    logic [15:0] vlog;
    logic [3:0]  snap;
    bit          done_seen;

    cmp_search_ctrl_if #(.WIDTH(2)) bus ();

    cmp_search_ctrl #(.WIDTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Behavioural comparator: target on the a side, probe on the b side
    always_comb begin
        bus.cmp_g = 1'b0;
        bus.cmp_e = 1'b0;
        bus.cmp_l = 1'b0;
        if (force_gl) begin
            bus.cmp_g = 1'b1;
            bus.cmp_l = 1'b1;
        end else if (force_l) begin
            bus.cmp_l = 1'b1;
        end else begin
            bus.cmp_g = (target > bus.probe);
            bus.cmp_e = (target == bus.probe);
            bus.cmp_l = (target < bus.probe);
        end
    end

    // Count one comparison and report it if the observed value is not the required one
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Run one search from a start pulse to the done cycle (or a 20-cycle bound).
    // Returns latency in cycles after the start edge (0 = never done), number of sampled
    // probes, the sampled probes packed 2 bits each, probe_vld per cycle before done,
    // and {err,found,result} seen in the first cycle after start.
    task automatic applyStimulus(input logic [1:0] tgt, input bit fgl, input bit fl,
                                 input bit poke, output int lat_o, output int np_o,
                                 output logic [15:0] plog_o, output logic [15:0] vlog_o,
                                 output logic [3:0] snap_o);
        target   = tgt;
        force_gl = fgl;
        force_l  = fl;
        lat_o    = 0;
        np_o     = 0;
        plog_o   = '0;
        vlog_o   = '0;
        snap_o   = '1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            bus.start = poke && (cyc <= 2);
            if (cyc == 1) snap_o = {bus.err, bus.found, bus.result};
            if (bus.done) begin
                lat_o = cyc;
                break;
            end
            vlog_o = {vlog_o[14:0], bus.probe_vld};
            if (bus.probe_vld) begin
                plog_o = {plog_o[13:0], bus.probe};
                np_o++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        target    = 2'd0;
        force_gl  = 1'b0;
        force_l   = 1'b0;
        n_checks  = 0;
        n_pass    = 0;

        $display("[TB] reset values");
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_probe",     32'(bus.probe),     32'd0);
        checkOutput("rst_probe_vld", 32'(bus.probe_vld), 32'd0);
        checkOutput("rst_busy",      32'(bus.busy),      32'd0);
        checkOutput("rst_done",      32'(bus.done),      32'd0);
        checkOutput("rst_outs",      32'({bus.result, bus.found, bus.err}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("idle_done", 32'(bus.done), 32'd0);

`ifdef CMP_SEARCH_SETTLE_EN
        $display("[TB] settle build, target 2");
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, lat, np, plog, vlog, snap);
        checkOutput("s2_latency", 32'(lat),  32'd5);
        checkOutput("s2_nprobe",  32'(np),   32'd2);
        checkOutput("s2_probes",  32'(plog), 32'h6);
        checkOutput("s2_vld",     32'(vlog), 32'h5);
        checkOutput("s2_result",  32'(bus.result), 32'd2);
        checkOutput("s2_found",   32'(bus.found),  32'd1);
        checkOutput("s2_err",     32'(bus.err),    32'd0);

        $display("[TB] settle build, target 0");
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, lat, np, plog, vlog, snap);
        checkOutput("s0_latency", 32'(lat),  32'd5);
        checkOutput("s0_probes",  32'(plog), 32'h4);
        checkOutput("s0_clear",   32'(snap), 32'd0);
        checkOutput("s0_result",  32'({bus.result, bus.found, bus.err}), 32'b0010);
`else
        $display("[TB] target 3");
        applyStimulus(2'd3, 1'b0, 1'b0, 1'b0, lat, np, plog, vlog, snap);
        checkOutput("t3_latency", 32'(lat),  32'd4);
        checkOutput("t3_nprobe",  32'(np),   32'd3);
        checkOutput("t3_probes",  32'(plog), 32'h1B);
        checkOutput("t3_vld",     32'(vlog), 32'h7);
        checkOutput("t3_busy",    32'(bus.busy),   32'd1);
        checkOutput("t3_result",  32'(bus.result), 32'd3);
        checkOutput("t3_found",   32'(bus.found),  32'd1);
        checkOutput("t3_err",     32'(bus.err),    32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("t3_start_in_done", 32'(bus.busy), 32'd0);
        checkOutput("t3_done_pulse",    32'(bus.done), 32'd0);
        checkOutput("t3_result_held",   32'({bus.result, bus.found}), 32'b111);

        $display("[TB] target 0 with start poked while busy");
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, lat, np, plog, vlog, snap);
        checkOutput("t0_clear",   32'(snap), 32'd0);
        checkOutput("t0_latency", 32'(lat),  32'd3);
        checkOutput("t0_probes",  32'(plog), 32'h4);
        checkOutput("t0_vld",     32'(vlog), 32'h3);
        checkOutput("t0_outs",    32'({bus.result, bus.found, bus.err}), 32'b0010);
        @(negedge clk);
        checkOutput("t0_back_idle", 32'(bus.busy), 32'd0);

        $display("[TB] malformed flags");
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, lat, np, plog, vlog, snap);
        checkOutput("gl_latency", 32'(lat),        32'd2);
        checkOutput("gl_err",     32'(bus.err),    32'd1);
        checkOutput("gl_found",   32'(bus.found),  32'd0);
        checkOutput("gl_result",  32'(bus.result), 32'd1);

        $display("[TB] less-than at probe 0");
        applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, lat, np, plog, vlog, snap);
        checkOutput("l0_latency", 32'(lat),  32'd3);
        checkOutput("l0_probes",  32'(plog), 32'h4);
        checkOutput("l0_outs",    32'({bus.result, bus.found, bus.err}), 32'd0);
        force_l = 1'b0;

        $display("[TB] reset during search");
        target = 2'd3;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("mr_busy_before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        checkOutput("mr_probe_before", 32'(bus.probe), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mr_probe", 32'(bus.probe),     32'd0);
        checkOutput("mr_vld",   32'(bus.probe_vld), 32'd0);
        checkOutput("mr_busy",  32'(bus.busy),      32'd0);
        checkOutput("mr_done",  32'(bus.done),      32'd0);
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        checkOutput("mr_no_done", 32'(done_seen), 32'd0);
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, lat, np, plog, vlog, snap);
        checkOutput("mr_t2_latency", 32'(lat),  32'd3);
        checkOutput("mr_t2_probes",  32'(plog), 32'h6);
        checkOutput("mr_t2_outs",    32'({bus.result, bus.found, bus.err}), 32'b1010);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
